// File: rtl/alu_operand_stage_if.sv
// Command handshake between a controller and the ALU operand stage.
// The controller drives a request and its fields; the stage reports busy/done.
interface alu_operand_stage_if;
  logic       start;
  logic [2:0] rn;
  logic [2:0] rm;
  logic [2:0] rd;
  logic [1:0] op;
  logic [1:0] shift;
  logic       asel;
  logic       wb_en;
  logic       busy;
  logic       done;

  // Controller side: issues commands, observes status
  modport master (
    output start, rn, rm, rd, op, shift, asel, wb_en,
    input  busy, done
  );

  // Operand stage side: accepts commands, reports status
  modport slave (
    input  start, rn, rm, rd, op, shift, asel, wb_en,
    output busy, done
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Multi-cycle operand/result stage wrapped around an external 16-bit ALU.
// It owns an NREGS x WIDTH register file and the A, B and C registers, and it
// sequences one operation as IDLE -> LOAD_A -> LOAD_B -> EXEC -> WB -> IDLE.
// The ALU itself is outside this block: alu_a/alu_b/alu_op go out, and
// alu_out/alu_z come back and are captured during EXEC.
module alu_operand_stage #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_operand_stage_if.slave cmd,
  input  logic             ext_we,
  input  logic [2:0]       ext_waddr,
  input  logic [WIDTH-1:0] ext_wdata,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  output logic [WIDTH-1:0] c_out,
  output logic             z_flag
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // B-operand shift encodings
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  state_t           state_q, state_d;

  // Operand and result registers
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             z_q, z_d;
  logic             done_q, done_d;

  // Command fields captured when a start is accepted in IDLE
  logic [2:0]       rn_q, rn_d;
  logic [2:0]       rm_q, rm_d;
  logic [2:0]       rd_q, rd_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       shift_q, shift_d;
  logic             asel_q, asel_d;
  logic             wb_en_q, wb_en_d;

  // Register file
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  // Shifted view of R[rm], loaded into B during LOAD_B
  logic [WIDTH-1:0] shift_src;
  logic [WIDTH-1:0] shift_res;

  // Apply the latched 1-bit shift to the B source register; ASR keeps the sign bit
  always_comb begin
    shift_src = regs_q[rm_q];
    shift_res = shift_src;
    case (shift_q)
      SH_NONE: shift_res = shift_src;
      SH_LSL1: shift_res = {shift_src[WIDTH-2:0], 1'b0};
      SH_LSR1: shift_res = {1'b0, shift_src[WIDTH-1:1]};
      SH_ASR1: shift_res = {shift_src[WIDTH-1], shift_src[WIDTH-1:1]};
      default: shift_res = shift_src;
    endcase
  end

  // Next-state and next-register logic for the whole sequencer
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    z_d     = z_q;
    done_d  = 1'b0;
    rn_d    = rn_q;
    rm_d    = rm_q;
    rd_d    = rd_q;
    op_d    = op_q;
    shift_d = shift_q;
    asel_d  = asel_q;
    wb_en_d = wb_en_q;
    regs_d  = regs_q;

    case (state_q)
      S_IDLE: begin
        // External writes are only honoured while idle, so they can never
        // collide with an internal write-back. A write in the same cycle as
        // start lands first and is seen by the following LOAD states.
        if (ext_we) begin
          regs_d[ext_waddr] = ext_wdata;
        end
        if (cmd.start) begin
          rn_d    = cmd.rn;
          rm_d    = cmd.rm;
          rd_d    = cmd.rd;
          op_d    = cmd.op;
          shift_d = cmd.shift;
          asel_d  = cmd.asel;
          wb_en_d = cmd.wb_en;
          state_d = S_LOAD_A;
        end
      end

      S_LOAD_A: begin
        a_d     = regs_q[rn_q];
        state_d = S_LOAD_B;
      end

      S_LOAD_B: begin
        b_d     = shift_res;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        // A and B have been stable since LOAD_B, so the ALU result is settled
        c_d     = alu_out;
        z_d     = alu_z;
        state_d = S_WB;
      end

      S_WB: begin
        if (wb_en_q) begin
          regs_d[rd_q] = c_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register every piece of state; synchronous active-low reset clears it all
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      op_q    <= '0;
      shift_q <= '0;
      asel_q  <= 1'b0;
      wb_en_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
      done_q  <= done_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
      shift_q <= shift_d;
      asel_q  <= asel_d;
      wb_en_q <= wb_en_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // ALU drive and status outputs, all taken straight from registers
  assign alu_a    = asel_q ? '0 : a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign c_out    = c_q;
  assign z_flag   = z_q;
  assign dbg_data = regs_q[dbg_addr];
  assign cmd.busy = (state_q != S_IDLE);
  assign cmd.done = done_q;

endmodule
